// File: rtl/data_memory.sv
// Byte-addressed 12 KiB data memory: synchronous sub-word stores, combinational extended loads.
// Define DM_DISPLAY_EN to log every accepted store as "time@pc: *addr <= word".
module data_memory #(
  parameter int DEPTH_WORDS = 3072,
  parameter int INDEX_BITS  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD
);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  localparam logic [INDEX_BITS:0] DEPTH_L =
    (INDEX_BITS+1)'(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [INDEX_BITS-1:0] idx;
  logic                  in_range;
  logic [31:0]           rword;
  logic [15:0]           half;
  logic [7:0]            bsel;
  logic [31:0]           word_d;
  logic                  wr_en;

  assign idx = Addr[INDEX_BITS+1:2];
  assign in_range = (Addr[31:INDEX_BITS+2] == '0) &&
                    ({1'b0, idx} < DEPTH_L);

  always_comb begin
    rword = '0;
    if (in_range) rword = mem_q[idx];
    half = Addr[1] ? rword[31:16] : rword[15:0];
    bsel = rword[7:0];
    case (Addr[1:0])
      2'd1: bsel = rword[15:8];
      2'd2: bsel = rword[23:16];
      2'd3: bsel = rword[31:24];
      default: bsel = rword[7:0];
    endcase
  end

  always_comb begin
    RD = '0;
    case (MemOp)
      OP_W:  RD = rword;
      OP_HS: RD = {{16{half[15]}}, half};
      OP_HU: RD = {16'h0, half};
      OP_BS: RD = {{24{bsel[7]}}, bsel};
      OP_BU: RD = {24'h0, bsel};
      default: RD = '0;
    endcase
  end

  // Sub-word stores merge into the current word; reserved codes never write.
  always_comb begin
    word_d = rword;
    wr_en  = 1'b0;
    case (MemOp)
      OP_W: begin
        word_d = WD;
        wr_en  = MemWrite && in_range;
      end
      OP_HS, OP_HU: begin
        if (Addr[1]) word_d[31:16] = WD[15:0];
        else         word_d[15:0]  = WD[15:0];
        wr_en = MemWrite && in_range;
      end
      OP_BS, OP_BU: begin
        case (Addr[1:0])
          2'd0: word_d[7:0]   = WD[7:0];
          2'd1: word_d[15:8]  = WD[7:0];
          2'd2: word_d[23:16] = WD[7:0];
          default: word_d[31:24] = WD[7:0];
        endcase
        wr_en = MemWrite && in_range;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= word_d;
`ifdef DM_DISPLAY_EN
      $display("%d@%h: *%h <= %h", $time, PC,
               {Addr[31:2], 2'b00}, word_d);
`endif
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Each task drives one scenario and compares RD against hand-computed values.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] RD;

  int pass_cnt = 0;
  int total_cnt = 0;

  data_memory dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite),
    .MemOp(MemOp), .Addr(Addr), .WD(WD), .PC(PC), .RD(RD)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    MemOp = op; Addr = a; WD = d; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic set_load(input logic [2:0] op,
                          input logic [31:0] a);
    MemOp = op; Addr = a;
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h2FFC; addrs[2] = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      set_load(3'b000, addrs[i]);
      total_cnt++;
      if (RD !== 32'h0)
        $display("FAIL reset_lw_%h: got %h want 00000000", addrs[i], RD);
      else pass_cnt++;
    end
    do_store(3'b000, 32'h40, 32'h12345678);
    total_cnt++;
    if (RD !== 32'h12345678)
      $display("FAIL pre_reset_lw40: got %h want 12345678", RD);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL async_reset_lw40: got %h want 00000000", RD);
    else pass_cnt++;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL post_reset_lw40: got %h want 00000000", RD);
    else pass_cnt++;
  endtask

  task automatic test_byte_loads;
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    exp_s[0] = 32'h00000001; exp_u[0] = 32'h00000001;
    exp_s[1] = 32'h0000007F; exp_u[1] = 32'h0000007F;
    exp_s[2] = 32'hFFFFFFFF; exp_u[2] = 32'h000000FF;
    exp_s[3] = 32'hFFFFFF80; exp_u[3] = 32'h00000080;
    do_store(3'b000, 32'h100, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      set_load(3'b011, 32'h100 + 32'(i));
      total_cnt++;
      if (RD !== exp_s[i])
        $display("FAIL lb_10%0d: got %h want %h", i, RD, exp_s[i]);
      else pass_cnt++;
      set_load(3'b100, 32'h100 + 32'(i));
      total_cnt++;
      if (RD !== exp_u[i])
        $display("FAIL lbu_10%0d: got %h want %h", i, RD, exp_u[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_partial;
    do_store(3'b000, 32'h200, 32'hAAAAAAAA);
    do_store(3'b001, 32'h202, 32'h00001234);
    do_store(3'b011, 32'h200, 32'h00000055);
    set_load(3'b000, 32'h200);
    total_cnt++;
    if (RD !== 32'h1234AA55)
      $display("FAIL merge_lw200: got %h want 1234AA55", RD);
    else pass_cnt++;
    set_load(3'b001, 32'h202);
    total_cnt++;
    if (RD !== 32'h00001234)
      $display("FAIL lh202: got %h want 00001234", RD);
    else pass_cnt++;
    set_load(3'b010, 32'h200);
    total_cnt++;
    if (RD !== 32'h0000AA55)
      $display("FAIL lhu200: got %h want 0000AA55", RD);
    else pass_cnt++;
    set_load(3'b001, 32'h200);
    total_cnt++;
    if (RD !== 32'hFFFFAA55)
      $display("FAIL lh200: got %h want FFFFAA55", RD);
    else pass_cnt++;
    set_load(3'b101, 32'h200);
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL reserved_load: got %h want 00000000", RD);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range;
    do_store(3'b000, 32'h2FFC, 32'h0BADF00D);
    set_load(3'b000, 32'h2FFC);
    total_cnt++;
    if (RD !== 32'h0BADF00D)
      $display("FAIL last_word: got %h want 0BADF00D", RD);
    else pass_cnt++;
    do_store(3'b000, 32'h3000, 32'hDEADBEEF);
    do_store(3'b000, 32'h80000000, 32'hDEADBEEF);
    set_load(3'b000, 32'h3000);
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL oor_3000: got %h want 00000000", RD);
    else pass_cnt++;
    set_load(3'b000, 32'h80000000);
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL oor_80000000: got %h want 00000000", RD);
    else pass_cnt++;
    set_load(3'b000, 32'h0);
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL oor_lw0: got %h want 00000000", RD);
    else pass_cnt++;
    set_load(3'b000, 32'h2FFC);
    total_cnt++;
    if (RD !== 32'h0BADF00D)
      $display("FAIL oor_lastword: got %h want 0BADF00D", RD);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    @(negedge clk);
    reset = 1'b1;
    MemOp = 3'b000; Addr = 32'h20; WD = 32'hFFFFFFFF;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    reset = 1'b0;
    set_load(3'b000, 32'h20);
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL reset_vs_write: got %h want 00000000", RD);
    else pass_cnt++;
    do_store(3'b101, 32'h30, 32'h5A5A5A5A);
    set_load(3'b000, 32'h30);
    total_cnt++;
    if (RD !== 32'h0)
      $display("FAIL reserved_store: got %h want 00000000", RD);
    else pass_cnt++;
  endtask

  task automatic test_rdw;
    do_store(3'b000, 32'h10, 32'h11111111);
    @(negedge clk);
    MemOp = 3'b000; Addr = 32'h10; WD = 32'hCAFEF00D;
    MemWrite = 1'b1;
    #1;
    total_cnt++;
    if (RD !== 32'h11111111)
      $display("FAIL rdw_before: got %h want 11111111", RD);
    else pass_cnt++;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    total_cnt++;
    if (RD !== 32'hCAFEF00D)
      $display("FAIL rdw_after: got %h want CAFEF00D", RD);
    else pass_cnt++;
    do_store(3'b100, 32'h11, 32'h000000EE);
    do_store(3'b010, 32'h12, 32'h0000BEEF);
    set_load(3'b000, 32'h10);
    total_cnt++;
    if (RD !== 32'hBEEFEE0D)
      $display("FAIL back_to_back: got %h want BEEFEE0D", RD);
    else pass_cnt++;
  endtask

  task automatic test_display;
    PC = 32'h00003008;
    do_store(3'b011, 32'h7, 32'h000000CC);
    set_load(3'b000, 32'h4);
    total_cnt++;
    if (RD !== 32'hCC000000)
      $display("FAIL sb_7: got %h want CC000000", RD);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    MemWrite = 1'b0;
    MemOp = 3'b000;
    Addr = 32'h0;
    WD = 32'h0;
    PC = 32'h0;
    #12;
    reset = 1'b0;
    test_reset();
    test_byte_loads();
    test_partial();
    test_out_of_range();
    test_collision();
    test_rdw();
    test_display();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle datapath.
- Consumes ALUResult as the byte address, plus the GRF rt value as store data.
- Performs word, halfword and byte stores synchronously, and word/half/byte loads combinationally.
- Load data is sign- or zero-extended per the access code and drives the GRF write-back mux.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words stored (12 KiB).
- INDEX_BITS, 12, width of the word index taken from Addr[INDEX_BITS+1:2].

Ports:
- clk  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-high; clears the whole array
- MemWrite  input  1  store enable for the current cycle
- MemOp  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, others reserved
- Addr  input  32  byte address (ALUResult)
- WD  input  32  store data (rt); low half or low byte used for sub-word stores
- PC  input  32  PC of the current instruction; used only by the optional log
- RD  output  32  extended load data

Behaviour:
- Storage: DEPTH_WORDS x 32 array, little-endian byte lanes. Byte k of a word is bits [8k+7:8k].
- Reset:
  - While reset is high, every word is forced to 0, asynchronously and independent of clk.
  - RD therefore reads 0 for all in-range addresses.
  - Reset has priority over MemWrite: no store occurs at any edge where reset is high.
  - If reset rises mid-operation, the array clears immediately; a store pending that cycle is lost.
- Index:
  - idx = Addr[INDEX_BITS+1:2].
  - Out of range when Addr[31:INDEX_BITS+2] != 0 or idx >= DEPTH_WORDS.
  - Out-of-range stores are ignored. Out-of-range loads return RD = 0.
- Alignment:
  - Word access ignores Addr[1:0].
  - Half access ignores Addr[0] and uses Addr[1] to select the half.
  - Byte access uses Addr[1:0] to select the byte.
  - No misalignment fault is raised.
- Store (rising clk edge, reset low, MemWrite=1, in range):
  - 000: word <= WD.
  - 001/010: the selected half <= WD[15:0]; the other half is unchanged.
  - 011/100: the selected byte <= WD[7:0]; the other bytes are unchanged.
  - Reserved codes: no write.
- Load (combinational, zero latency from Addr/MemOp):
  - 000: full word.
  - 001: sign-extended half.
  - 010: zero-extended half.
  - 011: sign-extended byte.
  - 100: zero-extended byte.
  - Reserved codes: 0.
  - RD is independent of MemWrite.
- Read-during-write, same address: RD shows the old contents until the edge and the new contents after it. There is no bypass.
- Successive stores to the same word on consecutive cycles accumulate correctly; partial writes merge with current contents.

Optional Feature:
- Macro DM_DISPLAY_EN.
- When defined, each accepted store prints `$display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2],2'b00}, newword)`, where newword is the full merged 32-bit word after the write. Ignored stores (out of range, reserved code, or reset high) print nothing.
- When undefined, no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then load word at 0x0, 0x2FFC and 0x1000 -> RD=0x00000000 for each. Assert reset mid-run after storing 0x12345678 at 0x40 (asynchronous, between edges) -> RD at 0x40 becomes 0 immediately.
- sw 0x80FF7F01 at 0x100; load codes 011/100 at 0x100..0x103:
  - 0x100 -> 0x00000001 / 0x00000001
  - 0x101 -> 0x0000007F / 0x0000007F
  - 0x102 -> 0xFFFFFFFF / 0x000000FF
  - 0x103 -> 0xFFFFFF80 / 0x00000080
- Partial stores: sw 0xAAAAAAAA at 0x200; sh WD=0x00001234 at 0x202; sb WD=0x55 at 0x200 -> lw 0x200 = 0x1234AA55. lh 0x202 = 0x00001234; lhu 0x200 = 0x0000AA55; lh 0x200 = 0xFFFFAA55.
- Out of range: sw 0xDEADBEEF at 0x3000 and at 0x80000000 -> no change anywhere; RD=0 at both. lw 0x0 still 0. With DM_DISPLAY_EN defined, no log lines are printed.
- Write/reset collision and read-during-write:
  - MemWrite=1 with reset high across an edge -> word stays 0.
  - Store at 0x10 -> RD shows the old value before the edge and the new value one delta after it.
- With DM_DISPLAY_EN and PC=0x00003008, sb WD=0xCC at 0x7 -> exactly one line containing "@00003008: *00000004 <= cc000000".
